// File: rtl/symmetric_fir_core.sv
// Symmetric/antisymmetric FIR core with pre-adder folding, a four-register
// pipeline and double-buffered coefficients (shadow bank, committed to active).
module symmetric_fir_core #(
  parameter int DATA_WL  = 14,
  parameter int DATA_FL  = 6,
  parameter int COEFF_WL = 9,
  parameter int COEFF_FL = 7,
  parameter int ORDER    = 9,
  parameter int ANTISYM  = 1,
  parameter int OUT_WL   = 20,
  parameter int OUT_FL   = 12,
  parameter logic [((ORDER+1)/2)*COEFF_WL-1:0] COEFF_INIT =
    {9'h019, 9'h1CD, 9'h0FF, 9'h007, 9'h013},
  localparam int TAPS  = ORDER + 1,
  localparam int NCOEF = TAPS / 2,
  localparam int AW    = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_WL-1:0]  in_data,
  input  logic                coeff_we,
  input  logic [AW-1:0]       coeff_addr,
  input  logic [COEFF_WL-1:0] coeff_wdata,
  input  logic                coeff_commit,
  output logic                out_valid,
  output logic [OUT_WL-1:0]   out_data,
  output logic                sat
);

  localparam int PW   = DATA_WL + 1;
  localparam int MW   = PW + COEFF_WL;
  localparam int SW   = MW + $clog2(NCOEF);
  localparam int IFL  = DATA_FL + COEFF_FL;
  localparam int RSH  = (IFL > OUT_FL) ? IFL - OUT_FL : 0;
  localparam int LSH  = (OUT_FL > IFL) ? OUT_FL - IFL : 0;
  localparam int HALF = (1 << RSH) >> 1;
  localparam int XW   = (SW + 1 + LSH > OUT_WL + 1) ? SW + 1 + LSH : OUT_WL + 1;
  localparam logic signed [XW-1:0] OMAX = {{(XW-OUT_WL+1){1'b0}}, {(OUT_WL-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-OUT_WL+1){1'b1}}, {(OUT_WL-1){1'b0}}};

  // Valid semantics: a sample is accepted on every edge where in_valid is 1
  // (no backpressure); its valid tag travels x -> m -> sum -> out alongside it,
  // so out_valid is in_valid delayed by exactly four cycles.
  logic signed [DATA_WL-1:0]  x_q      [TAPS];
  logic signed [COEFF_WL-1:0] shadow_q [NCOEF];
  logic signed [COEFF_WL-1:0] active_q [NCOEF];
  logic signed [PW-1:0]       p        [NCOEF];
  logic signed [MW-1:0]       m_q      [NCOEF];
  logic signed [SW-1:0]       sum_d, sum_q;
  logic signed [XW-1:0]       sum_x, rounded, aligned;
  logic signed [OUT_WL-1:0]   out_d, out_q;
  logic                       sat_d, sat_q;
  logic                       x_vld_q, m_vld_q, sum_vld_q, out_vld_q;

  always_comb begin
    for (int k = 0; k < NCOEF; k++) begin
      if (ANTISYM != 0) p[k] = PW'(x_q[k]) - PW'(x_q[TAPS-1-k]);
      else              p[k] = PW'(x_q[k]) + PW'(x_q[TAPS-1-k]);
    end
    sum_d = '0;
    for (int k = 0; k < NCOEF; k++) sum_d = sum_d + SW'(m_q[k]);
  end

  // Round half-up when dropping fraction bits, zero-fill when adding them.
  always_comb begin
    sum_x   = XW'(sum_q);
    rounded = sum_x + XW'(HALF);
    aligned = (rounded >>> RSH) <<< LSH;
    sat_d   = 1'b0;
    out_d   = aligned[OUT_WL-1:0];
    if (aligned > OMAX) begin
      out_d = {1'b0, {(OUT_WL-1){1'b1}}};
      sat_d = 1'b1;
    end else if (aligned < OMIN) begin
      out_d = {1'b1, {(OUT_WL-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++)  x_q[k] <= '0;
      for (int k = 0; k < NCOEF; k++) m_q[k] <= '0;
      sum_q     <= '0;
      out_q     <= '0;
      sat_q     <= 1'b0;
      x_vld_q   <= 1'b0;
      m_vld_q   <= 1'b0;
      sum_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
        x_q[0] <= in_data;
      end
      x_vld_q <= in_valid;
      for (int k = 0; k < NCOEF; k++) m_q[k] <= MW'(p[k]) * MW'(active_q[k]);
      m_vld_q   <= x_vld_q;
      sum_q     <= sum_d;
      sum_vld_q <= m_vld_q;
      out_q     <= out_d;
      sat_q     <= sum_vld_q & sat_d;
      out_vld_q <= sum_vld_q;
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle write only lands in shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCOEF; k++) begin
        shadow_q[k] <= COEFF_INIT[(NCOEF-1-k)*COEFF_WL +: COEFF_WL];
        active_q[k] <= COEFF_INIT[(NCOEF-1-k)*COEFF_WL +: COEFF_WL];
      end
    end else begin
      if (coeff_commit) begin
        for (int k = 0; k < NCOEF; k++) active_q[k] <= shadow_q[k];
      end
      if (coeff_we && ({1'b0, coeff_addr} < (AW+1)'(NCOEF))) begin
        shadow_q[coeff_addr] <= coeff_wdata;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_symmetric_fir_core.sv
// Directed-vector bench for symmetric_fir_core: an antisymmetric (default) and
// a symmetric instance share the stimulus; per-cycle expectations live in a table.
module tb_symmetric_fir_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, coeff_we, coeff_commit;
  logic [13:0] in_data;
  logic [2:0]  coeff_addr;
  logic [8:0]  coeff_wdata;
  logic        ov_a, sat_a, ov_s, sat_s;
  logic [19:0] od_a, od_s;

  always #5 clk = ~clk;

  symmetric_fir_core #(.ANTISYM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .coeff_commit(coeff_commit), .out_valid(ov_a), .out_data(od_a), .sat(sat_a)
  );

  symmetric_fir_core #(.ANTISYM(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .coeff_commit(coeff_commit), .out_valid(ov_s), .out_data(od_s), .sat(sat_s)
  );

  typedef struct {
    logic        vld;
    logic [13:0] din;
    logic        we;
    logic [2:0]  addr;
    logic [8:0]  wd;
    logic        cmt;
    logic        ev;
    logic        chk;
    logic [19:0] ed;
    logic        es;
  } vec_t;

  vec_t tbl [0:63];
  int   tbl_n  = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Default coefficients 25,-51,255,7,19 (FL7); 1.0 impulse gives c*32 at FL12.
  int imp_e [10] = '{800, -1632, 8160, 224, 608, -608, -224, -8160, 1632, -800};
  int rnd_e [10] = '{13, -25, 128, 4, 10, -9, -3, -127, 26, -12};
  int c0z_e [10] = '{0, -1632, 8160, 224, 608, -608, -224, -8160, 1632, 0};
  int ac_e  [10] = '{3200, -3328, 29312, 30208, 32640, 30208, 29312, -3328, 3200, 0};
  int gev   [12] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0};
  int ged   [12] = '{0, 0, 0, 0, 800, 0, 0, -1632, 8160, 0, 224, 0};
  int gv    [12] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
  int gd    [12] = '{64, 'h1234, 'h0abc, 0, 0, 'h3fff, 0, 0, 0, 0, 0, 0};

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; coeff_we = 1'b0; coeff_addr = '0;
    coeff_wdata = '0; coeff_commit = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic v, input int d, input logic ev, input logic chk,
                     input int ed, input logic es);
    tbl[tbl_n].vld  = v;
    tbl[tbl_n].din  = 14'(d);
    tbl[tbl_n].we   = 1'b0;
    tbl[tbl_n].addr = '0;
    tbl[tbl_n].wd   = '0;
    tbl[tbl_n].cmt  = 1'b0;
    tbl[tbl_n].ev   = ev;
    tbl[tbl_n].chk  = chk;
    tbl[tbl_n].ed   = 20'(ed);
    tbl[tbl_n].es   = es;
    tbl_n++;
  endtask

  task automatic set_ctrl(input int idx, input logic we, input int addr, input int wd,
                          input logic cmt);
    tbl[idx].we   = we;
    tbl[idx].addr = 3'(addr);
    tbl[idx].wd   = 9'(wd);
    tbl[idx].cmt  = cmt;
  endtask

  // Ten valid samples (din then zeros) plus four flush cycles; outputs land 4 rows later.
  task automatic add_imp(input int din, input int e [10], input int n);
    int b;
    b = tbl_n;
    for (int j = 0; j < 14; j++) add(j < 10, (j == 0) ? din : 0, 1'b0, 1'b0, 0, 1'b0);
    for (int j = 0; j < 10; j++) begin
      tbl[b+4+j].ev = 1'b1;
      if (j < n) begin
        tbl[b+4+j].chk = 1'b1;
        tbl[b+4+j].ed  = 20'(e[j]);
      end
    end
  endtask

  task automatic run_tbl(input logic sel, input string tag);
    logic        ov, st;
    logic [19:0] od;
    for (int i = 0; i < tbl_n; i++) begin
      in_valid     = tbl[i].vld;
      in_data      = tbl[i].din;
      coeff_we     = tbl[i].we;
      coeff_addr   = tbl[i].addr;
      coeff_wdata  = tbl[i].wd;
      coeff_commit = tbl[i].cmt;
      @(negedge clk);
      ov = sel ? ov_s : ov_a;
      od = sel ? od_s : od_a;
      st = sel ? sat_s : sat_a;
      check($sformatf("%s[%0d].out_valid", tag, i), {19'd0, ov}, {19'd0, tbl[i].ev});
      if (tbl[i].chk) begin
        check($sformatf("%s[%0d].out_data", tag, i), od, tbl[i].ed);
        check($sformatf("%s[%0d].sat", tag, i), {19'd0, st}, {19'd0, tbl[i].es});
      end else if (!tbl[i].ev) begin
        check($sformatf("%s[%0d].sat_idle", tag, i), {19'd0, st}, 20'd0);
      end
      step();
    end
    idle_inputs();
    tbl_n = 0;
  endtask

  initial begin
    int idx;
    logic pos, neg;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset.out_valid_a", {19'd0, ov_a}, 20'd0);
    check("reset.out_data_a", od_a, 20'd0);
    check("reset.sat_a", {19'd0, sat_a}, 20'd0);
    check("reset.out_valid_s", {19'd0, ov_s}, 20'd0);
    check("reset.out_data_s", od_s, 20'd0);
    check("reset.sat_s", {19'd0, sat_s}, 20'd0);
    step();
    rst_n = 1'b1;

    add_imp(64, imp_e, 10);
    run_tbl(1'b0, "impulse");
    add_imp(1, rnd_e, 10);
    run_tbl(1'b0, "round");

    do_reset();
    for (int i = 0; i < 26; i++) begin
      idx = (i < 4) ? 0 : ((i - 4 > 9) ? 9 : i - 4);
      add(i < 20, 'h100, (i >= 4) && (i < 24), (i >= 4) && (i < 24), ac_e[idx], 1'b0);
    end
    run_tbl(1'b0, "antisym_const");

    do_reset();
    for (int i = 0; i < 12; i++) add(gv[i] != 0, gd[i], gev[i] != 0, gev[i] != 0, ged[i], 1'b0);
    run_tbl(1'b0, "gaps");

    do_reset();
    for (int k = 0; k < 5; k++) begin
      add(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
      set_ctrl(tbl_n - 1, 1'b1, k, 'h0ff, 1'b0);
    end
    add(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    set_ctrl(tbl_n - 1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 34; i++) begin
      pos = (i >= 4) && (i <= 17);
      neg = (i >= 27) && (i <= 31);
      add(i < 28, (i < 14) ? 'h1fff : 'h2000, (i >= 4) && (i < 32), pos || neg,
          pos ? 'h7ffff : (neg ? 'h80000 : 0), pos || neg);
    end
    run_tbl(1'b1, "sym_sat");

    do_reset();
    add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(0, 1'b1, 5, 0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(1, 1'b1, 0, 0, 1'b1);
    add_imp(64, imp_e, 10);
    add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(tbl_n - 1, 1'b0, 0, 0, 1'b1);
    add_imp(64, c0z_e, 10);
    run_tbl(1'b0, "we_commit_same");

    do_reset();
    for (int i = 0; i < 9; i++) add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(0, 1'b1, 0, 0, 1'b0);
    tbl[1].vld = 1'b1; tbl[1].din = 14'd64;
    tbl[2].vld = 1'b1; tbl[2].din = 14'd64;
    set_ctrl(2, 1'b0, 0, 0, 1'b1);
    tbl[5].ev = 1'b1; tbl[5].chk = 1'b1; tbl[5].ed = 20'd800;
    tbl[6].ev = 1'b1; tbl[6].chk = 1'b1; tbl[6].ed = 20'(-1632);
    run_tbl(1'b0, "commit_stream");

    do_reset();
    add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(0, 1'b1, 2, 0, 1'b0);
    add(1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    set_ctrl(1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 7; i++) add(1'b1, (i == 0) ? 64 : 0, 1'b0, 1'b0, 0, 1'b0);
    tbl[6].ev = 1'b1; tbl[6].chk = 1'b1; tbl[6].ed = 20'd800;
    tbl[7].ev = 1'b1; tbl[7].chk = 1'b1; tbl[7].ed = 20'(-1632);
    tbl[8].ev = 1'b1; tbl[8].chk = 1'b1; tbl[8].ed = 20'd0;
    run_tbl(1'b0, "pre_reset");
    in_valid = 1'b1;
    @(negedge clk);
    check("mid.out_valid_before", {19'd0, ov_a}, 20'd1);
    check("mid.out_data_before", od_a, 20'd224);
    rst_n = 1'b0;
    #1;
    check("mid.out_valid_async", {19'd0, ov_a}, 20'd0);
    check("mid.out_data_async", od_a, 20'd0);
    check("mid.sat_async", {19'd0, sat_a}, 20'd0);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) add(1'b0, 0, 1'b0, 1'b1, 0, 1'b0);
    add_imp(64, imp_e, 10);
    run_tbl(1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
